// File: rtl/dzcpu_uop_sequencer.sv
// Micro-op sequencer: fetches an opcode, maps it through the opcode LUTs to a
// micro-op flow, and steps that flow until an end marker or interrupt entry.
module dzcpu_uop_sequencer #(
  parameter logic [7:0] INT_FLOW_IDX = 8'd167,
  parameter int         ERR_SAT      = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMemData,
  input  logic        iMemReady,
  input  logic [12:0] iUop,
  input  logic [7:0]  iLutIdx,
  input  logic [7:0]  iCbLutIdx,
  input  logic        iZeroFlag,
  input  logic        iIntPending,
  input  logic        iStall,
  output logic [7:0]  oOpcode,
  output logic [7:0]  oCbOpcode,
  output logic [7:0]  oUopAddr,
  output logic        oUopValid,
  output logic        oPcInc,
  output logic        oFlagUpdate,
  output logic        oIntAck,
  output logic        oSeqError
);

  localparam logic [3:0] FLOW_NOP          = 4'd0;
  localparam logic [3:0] FLOW_OP           = 4'd1;
  localparam logic [3:0] FLOW_INC          = 4'd2;
  localparam logic [3:0] FLOW_EOF          = 4'd3;
  localparam logic [3:0] FLOW_INC_EOF      = 4'd4;
  localparam logic [3:0] FLOW_EOF_FU       = 4'd5;
  localparam logic [3:0] FLOW_INC_EOF_FU   = 4'd6;
  localparam logic [3:0] FLOW_UPDATE_FLAGS = 4'd7;
  localparam logic [3:0] FLOW_INC_EOF_Z    = 4'd8;
  localparam logic [3:0] FLOW_INC_EOF_NZ   = 4'd9;
  localparam logic [4:0] OP_JCB            = 5'd19;

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_DECODE   = 2'd1,
    S_CBDECODE = 2'd2,
    S_EXEC     = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] uop_addr_n, opcode_n, cb_opcode_n;
  logic       int_ack_n, seq_error_n;
  logic [3:0] flow;
  logic [4:0] oper;
  logic       flow_end, flow_inc, flow_fu;
  logic       unused_operand;

  assign flow           = iUop[12:9];
  assign oper           = iUop[8:4];
  assign unused_operand = ^iUop[3:0];

  // Returns {end, pc_inc, flag_update}; nop, op and unassigned codes just advance.
  function automatic logic [2:0] decode_flow(input logic [3:0] f, input logic z);
    case (f)
      FLOW_INC:          decode_flow = 3'b010;
      FLOW_EOF:          decode_flow = 3'b100;
      FLOW_INC_EOF:      decode_flow = 3'b110;
      FLOW_EOF_FU:       decode_flow = 3'b101;
      FLOW_INC_EOF_FU:   decode_flow = 3'b111;
      FLOW_UPDATE_FLAGS: decode_flow = 3'b001;
      FLOW_INC_EOF_Z:    decode_flow = {z, 2'b10};
      FLOW_INC_EOF_NZ:   decode_flow = {~z, 2'b10};
      default:           decode_flow = 3'b000;
    endcase
  endfunction

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state     <= S_FETCH;
      oUopAddr  <= 8'd0;
      oOpcode   <= 8'd0;
      oCbOpcode <= 8'd0;
      oIntAck   <= 1'b0;
      oSeqError <= 1'b0;
    end else begin
      state     <= state_n;
      oUopAddr  <= uop_addr_n;
      oOpcode   <= opcode_n;
      oCbOpcode <= cb_opcode_n;
      oIntAck   <= int_ack_n;
      oSeqError <= seq_error_n;
    end
  end

  always_comb begin
    {flow_end, flow_inc, flow_fu} = decode_flow(flow, iZeroFlag);
    oUopValid   = iReset && (state == S_EXEC) && !iStall;
    oPcInc      = oUopValid && flow_inc;
    oFlagUpdate = oUopValid && flow_fu;

    state_n     = state;
    uop_addr_n  = oUopAddr;
    opcode_n    = oOpcode;
    cb_opcode_n = oCbOpcode;
    int_ack_n   = 1'b0;
    seq_error_n = (ERR_SAT != 0) ? oSeqError : 1'b0;

    case (state)
      S_FETCH: begin
        if (iMemReady) begin
          if (iIntPending) begin
            int_ack_n  = 1'b1;
            uop_addr_n = INT_FLOW_IDX;
            state_n    = S_EXEC;
          end else begin
            opcode_n = iMemData;
            state_n  = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        uop_addr_n = iLutIdx;
        state_n    = S_EXEC;
      end
      S_CBDECODE: begin
        uop_addr_n = iCbLutIdx;
        state_n    = S_EXEC;
      end
      default: begin
        if (!iStall) begin
          // A CB prefix leaves the address alone; CBDECODE reloads it.
          if (oper == OP_JCB) begin
            cb_opcode_n = iMemData;
            state_n     = S_CBDECODE;
          end else if (flow_end) begin
            uop_addr_n = 8'd0;
            state_n    = S_FETCH;
          end else if (oUopAddr == 8'hFF) begin
            uop_addr_n  = 8'd0;
            seq_error_n = 1'b1;
            state_n     = S_FETCH;
          end else begin
            uop_addr_n = oUopAddr + 8'd1;
          end
        end
      end
    endcase
  end

endmodule
